// File: rtl/snd_dma_pkg.sv
// snd_dma_pkg: register indices, control bit positions and sequencer states for the sound DMA.
package snd_dma_pkg;
    localparam logic [4:0] REG_CTRL    = 5'h00;
    localparam logic [4:0] REG_START_H = 5'h01;
    localparam logic [4:0] REG_START_M = 5'h02;
    localparam logic [4:0] REG_START_L = 5'h03;
    localparam logic [4:0] REG_CNT_H   = 5'h04;
    localparam logic [4:0] REG_CNT_M   = 5'h05;
    localparam logic [4:0] REG_CNT_L   = 5'h06;
    localparam logic [4:0] REG_END_H   = 5'h07;
    localparam logic [4:0] REG_END_M   = 5'h08;
    localparam logic [4:0] REG_END_L   = 5'h09;
    localparam int CTRL_PLAY = 0;
    localparam int CTRL_LOOP = 1;
    typedef enum logic [2:0] {IDLE, ARM, WAIT, REQ, LOAD, GAP, FEND} state_t;
endpackage

// File: rtl/snd_dma_regs.sv
// snd_dma_regs: CPU-visible sound DMA registers with first-cycle write strobe and read mux.
module snd_dma_regs
    import snd_dma_pkg::*;
#(
    parameter int ADDR_W = 23
) (
    input  logic              clk32,
    input  logic              resb,
    input  logic              CS,
    input  logic [4:0]        A,
    input  logic              RW,
    input  logic [15:0]       DIN,
    output logic [15:0]       DOUT,
    input  logic              clr_play,
    input  logic [ADDR_W-1:0] cnt,
    output logic [ADDR_W-1:0] start_a,
    output logic [ADDR_W-1:0] end_a,
    output logic              loop,
    output logic              play_live
);
    logic        cs_d, we, play;
    logic [23:0] start_b, end_b, cnt_b;
    logic [7:0]  rd;
    logic        unused;
    assign we        = CS & ~RW & ~cs_d;
    assign cnt_b     = 24'({cnt, 1'b0});
    assign start_a   = start_b[ADDR_W:1];
    assign end_a     = end_b[ADDR_W:1];
    assign unused    = ^DIN[15:8];
    // the sequencer must see a PLAY write in the very cycle it happens
    assign play_live = (we && A == REG_CTRL) ? DIN[CTRL_PLAY] : play;
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            cs_d    <= 1'b0;
            play    <= 1'b0;
            loop    <= 1'b0;
            start_b <= '0;
            end_b   <= '0;
        end else begin
            cs_d <= CS;
            if (clr_play) play <= 1'b0;
            if (we) begin
                case (A)
                    REG_CTRL: begin
                        play <= DIN[CTRL_PLAY];
                        loop <= DIN[CTRL_LOOP];
                    end
                    REG_START_H: start_b[23:16] <= DIN[7:0];
                    REG_START_M: start_b[15:8]  <= DIN[7:0];
                    REG_START_L: start_b[7:0]   <= {DIN[7:1], 1'b0};
                    REG_END_H:   end_b[23:16]   <= DIN[7:0];
                    REG_END_M:   end_b[15:8]    <= DIN[7:0];
                    REG_END_L:   end_b[7:0]     <= {DIN[7:1], 1'b0};
                    default: ;
                endcase
            end
        end
    end
    always_comb begin
        rd = '0;
        case (A)
            REG_CTRL: begin
                rd[CTRL_PLAY] = play;
                rd[CTRL_LOOP] = loop;
            end
            REG_START_H: rd = start_b[23:16];
            REG_START_M: rd = start_b[15:8];
            REG_START_L: rd = start_b[7:0];
            REG_CNT_H:   rd = cnt_b[23:16];
            REG_CNT_M:   rd = cnt_b[15:8];
            REG_CNT_L:   rd = cnt_b[7:0];
            REG_END_H:   rd = end_b[23:16];
            REG_END_M:   rd = end_b[15:8];
            REG_END_L:   rd = end_b[7:0];
            default:     rd = '0;
        endcase
        DOUT = (CS && RW) ? {8'h00, rd} : 16'h0000;
    end
endmodule

// File: rtl/ste_dma_snd_ctrl.sv
// ste_dma_snd_ctrl: STE sound DMA frame sequencer; fetches words while the shifter FIFO has room.
module ste_dma_snd_ctrl
    import snd_dma_pkg::*;
#(
    parameter int ADDR_W = 23
) (
    input  logic              clk32,
    input  logic              resb,
    input  logic              CS,
    input  logic [4:0]        A,
    input  logic              RW,
    input  logic [15:0]       DIN,
    output logic [15:0]       DOUT,
    input  logic              SREQ,
    input  logic              GNT,
    output logic              FREQ,
    output logic [ADDR_W-1:0] ADDR,
    output logic              SLOAD_N,
    output logic              SINT,
    output logic              ACTIVE
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_inc, end_s, start_a, end_a;
    logic              loop, play_live, clr_play;
    snd_dma_regs #(.ADDR_W(ADDR_W)) u_regs (
        .clk32     (clk32),
        .resb      (resb),
        .CS        (CS),
        .A         (A),
        .RW        (RW),
        .DIN       (DIN),
        .DOUT      (DOUT),
        .clr_play  (clr_play),
        .cnt       (cnt),
        .start_a   (start_a),
        .end_a     (end_a),
        .loop      (loop),
        .play_live (play_live)
    );
    assign cnt_inc = cnt + ADDR_W'(1);
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state <= IDLE;
            cnt   <= '0;
            end_s <= '0;
        end else begin
            state <= state_nx;
            if (state == ARM) begin
                cnt   <= start_a;
                end_s <= end_a;
            end else if (state == LOAD) begin
                cnt <= cnt_inc;
            end
        end
    end
    // a stop during LOAD/GAP lets the word land, then exits through GAP without SINT
    always_comb begin
        state_nx = state;
        clr_play = 1'b0;
        case (state)
            IDLE: state_nx = play_live ? ARM : IDLE;
            ARM:  state_nx = !play_live ? IDLE : (start_a == end_a) ? FEND : WAIT;
            WAIT: state_nx = !play_live ? IDLE : SREQ ? REQ : WAIT;
            REQ:  state_nx = !play_live ? IDLE : GNT ? LOAD : REQ;
            LOAD: state_nx = (cnt_inc == end_s && play_live) ? FEND : GAP;
            GAP:  state_nx = play_live ? WAIT : IDLE;
            FEND: begin
                state_nx = (loop && play_live) ? ARM : IDLE;
                clr_play = !(loop && play_live);
            end
            default: state_nx = IDLE;
        endcase
    end
    assign FREQ    = state == REQ;
    assign ADDR    = cnt;
    assign SLOAD_N = state != LOAD;
    assign SINT    = state == FEND;
    assign ACTIVE  = state != IDLE;
endmodule

// File: tb/tb_ste_dma_snd_ctrl.sv
// tb_ste_dma_snd_ctrl: directed self-checking bench for the STE sound DMA sequencer.
module tb_ste_dma_snd_ctrl;
    logic        clk32 = 1'b0, resb = 1'b0, CS = 1'b0, RW = 1'b1, SREQ = 1'b0, GNT = 1'b0;
    logic [4:0]  A = '0;
    logic [15:0] DIN = '0, DOUT, d;
    logic        FREQ, SLOAD_N, SINT, ACTIVE;
    logic [22:0] ADDR;
    int          n_chk = 0, n_err = 0, cyc = 0, sint_n = 0, sint_c = 0, freq_n = 0, n0;
    bit          auto_gnt = 1'b0;
    int          gnt_c[$], sload_c[$];
    logic [22:0] gnt_a[$];
    ste_dma_snd_ctrl dut (
        .clk32(clk32), .resb(resb), .CS(CS), .A(A), .RW(RW), .DIN(DIN), .DOUT(DOUT),
        .SREQ(SREQ), .GNT(GNT), .FREQ(FREQ), .ADDR(ADDR), .SLOAD_N(SLOAD_N),
        .SINT(SINT), .ACTIVE(ACTIVE)
    );
    always #5 clk32 = ~clk32;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk32);
        #1;
        CS = 1'b0;
        RW = 1'b1;
        cyc++;
        if (auto_gnt) GNT = FREQ;
        if (!SLOAD_N) sload_c.push_back(cyc);
        if (SINT) begin
            sint_n++;
            sint_c = cyc;
        end
        if (FREQ) freq_n++;
        if (GNT && FREQ) begin
            gnt_c.push_back(cyc);
            gnt_a.push_back(ADDR);
        end
    endtask
    task automatic clr_log();
        gnt_c.delete();
        gnt_a.delete();
        sload_c.delete();
        sint_n = 0;
        freq_n = 0;
    endtask
    task automatic put(input logic [4:0] a, input logic [7:0] v);
        CS = 1'b1;
        RW = 1'b0;
        A = a;
        DIN = {8'h00, v};
    endtask
    task automatic wr(input logic [4:0] a, input logic [7:0] v);
        put(a, v);
        step();
        step();
    endtask
    task automatic rd(input logic [4:0] a, output logic [15:0] v);
        CS = 1'b1;
        RW = 1'b1;
        A = a;
        #1 v = DOUT;
        CS = 1'b0;
    endtask
    task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
        wr(5'h01, s[23:16]);
        wr(5'h02, s[15:8]);
        wr(5'h03, s[7:0]);
        wr(5'h07, e[23:16]);
        wr(5'h08, e[15:8]);
        wr(5'h09, e[7:0]);
    endtask
    task automatic wait_freq(input string tag);
        for (int i = 0; i < 60 && !FREQ; i++) step();
        chk(tag, FREQ, 1);
    endtask
    initial begin
        repeat (2) step();
        chk("rst_freq", FREQ, 0);
        chk("rst_sload", SLOAD_N, 1);
        chk("rst_sint", SINT, 0);
        chk("rst_active", ACTIVE, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_dout", DOUT, 0);
        resb = 1'b1;
        step();
        rd(5'h00, d);
        chk("rst_ctrl", d, 0);
        wr(5'h03, 8'hFF);
        rd(5'h03, d);
        chk("lo_bit0", d, 16'h00FE);
        wr(5'h0A, 8'h55);
        rd(5'h0A, d);
        chk("unmapped", d, 0);
        // single frame, four words
        set_frame(24'h010000, 24'h010008);
        SREQ = 1'b1;
        auto_gnt = 1'b1;
        clr_log();
        put(5'h00, 8'h01);
        step();
        chk("f1_arm_active", ACTIVE, 1);
        chk("f1_arm_freq", FREQ, 0);
        step();
        chk("f1_wait_freq", FREQ, 0);
        step();
        chk("f1_t3_freq", FREQ, 1);
        for (int i = 0; i < 60 && sint_n == 0; i++) step();
        step();
        chk("f1_ngnt", gnt_a.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("f1_addr%0d", i), gnt_a[i], 23'h8000 + i);
        chk("f1_nsload", sload_c.size(), 4);
        chk("f1_sload_lat", sload_c[0] - gnt_c[0], 1);
        chk("f1_word_gap", gnt_c[1] - gnt_c[0], 4);
        chk("f1_nsint", sint_n, 1);
        chk("f1_sint_lat", sint_c - sload_c[3], 1);
        chk("f1_active_end", ACTIVE, 0);
        rd(5'h00, d);
        chk("f1_ctrl", d, 0);
        // looping frame with start rewritten mid-frame
        clr_log();
        wr(5'h00, 8'h03);
        for (int i = 0; i < 40 && gnt_a.size() < 1; i++) step();
        wr(5'h01, 8'h02);
        for (int i = 0; i < 200 && gnt_a.size() < 5; i++) step();
        chk("lp_ngnt", gnt_a.size(), 5);
        chk("lp_last_old", gnt_a[3], 23'h8003);
        chk("lp_new_start", gnt_a[4], 23'h10000);
        chk("lp_nsint", sint_n, 1);
        chk("lp_restart_lat", gnt_c[4] - sint_c, 3);
        wr(5'h00, 8'h00);
        repeat (10) step();
        chk("lp_stop_active", ACTIVE, 0);
        chk("lp_stop_sint", sint_n, 1);
        // empty frame
        set_frame(24'h030000, 24'h030000);
        clr_log();
        put(5'h00, 8'h01);
        step();
        chk("em_arm_sint", SINT, 0);
        step();
        chk("em_sint", SINT, 1);
        step();
        chk("em_active", ACTIVE, 0);
        chk("em_nfreq", freq_n, 0);
        // SREQ hold-off and counter readback, manual grants
        auto_gnt = 1'b0;
        SREQ = 1'b0;
        set_frame(24'h040000, 24'h040004);
        clr_log();
        put(5'h00, 8'h01);
        step();
        repeat (50) step();
        chk("sq_nfreq", freq_n, 0);
        chk("sq_active", ACTIVE, 1);
        rd(5'h04, d);
        chk("sq_cnt_hi", d, 16'h0004);
        SREQ = 1'b1;
        step();
        chk("sq_freq", FREQ, 1);
        chk("sq_addr", ADDR, 23'h20000);
        GNT = 1'b1;
        step();
        GNT = 1'b0;
        chk("sq_load", SLOAD_N, 0);
        step();
        chk("sq_gap", SLOAD_N, 1);
        rd(5'h06, d);
        chk("sq_cnt_lo1", d, 16'h0002);
        step();
        step();
        chk("sq_freq2", FREQ, 1);
        GNT = 1'b1;
        step();
        GNT = 1'b0;
        step();
        chk("sq_sint", SINT, 1);
        step();
        chk("sq_idle", ACTIVE, 0);
        rd(5'h06, d);
        chk("sq_cnt_lo2", d, 16'h0004);
        // stop written in the grant cycle
        set_frame(24'h050000, 24'h050008);
        clr_log();
        wr(5'h00, 8'h01);
        wait_freq("st_freq_wait");
        GNT = 1'b1;
        put(5'h00, 8'h00);
        step();
        GNT = 1'b0;
        chk("st_sload", SLOAD_N, 1);
        chk("st_freq", FREQ, 0);
        chk("st_active", ACTIVE, 0);
        repeat (5) step();
        chk("st_nsload", sload_c.size(), 0);
        chk("st_nsint", sint_n, 0);
        // asynchronous reset during REQ
        wr(5'h00, 8'h01);
        wait_freq("ar_freq_wait");
        #2 resb = 1'b0;
        #1;
        chk("ar_freq", FREQ, 0);
        chk("ar_sload", SLOAD_N, 1);
        chk("ar_sint", SINT, 0);
        chk("ar_active", ACTIVE, 0);
        chk("ar_addr", ADDR, 0);
        chk("ar_dout", DOUT, 0);
        rd(5'h01, d);
        chk("ar_start_hi", d, 0);
        step();
        resb = 1'b1;
        step();
        // counter wrap through zero
        auto_gnt = 1'b1;
        set_frame(24'hFFFFFE, 24'h000002);
        clr_log();
        wr(5'h00, 8'h01);
        for (int i = 0; i < 100 && sint_n == 0; i++) step();
        step();
        chk("wr_ngnt", gnt_a.size(), 2);
        chk("wr_addr0", gnt_a[0], 23'h7FFFFF);
        chk("wr_addr1", gnt_a[1], 23'h000000);
        chk("wr_nsint", sint_n, 1);
        chk("wr_active", ACTIVE, 0);
        n0 = n_chk;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ste_dma_snd_ctrl.md
# ste_dma_snd_ctrl

STE DMA sound frame sequencer on the MCU side of the audio path. It holds the frame start, end and counter address registers and the play/loop control. It requests memory cycles whenever the shifter audio FIFO signals room on SREQ, and strobes SLOAD_N so the shifter captures MDIN. It flags frame end for the MFP timer/GPIP interrupt.

## Interface
Parameters:
- ADDR_W, 23: word-address width; byte address bits [23:1].

Ports:
- clk32  in  1  system clock, 32 MHz.
- resb  in  1  reset, asynchronous, active-low; all state cleared immediately.
- CS  in  1  sound-DMA register select (0xFF8900–0xFF8913).
- A  in  5  word index A[5:1].
- RW  in  1  1 = read, 0 = write.
- DIN  in  16  CPU write data; only bits [7:0] are used.
- DOUT  out  16  register read data; bits [15:8] are always 0.
- SREQ  in  1  shifter FIFO not full.
- GNT  in  1  one-cycle bus grant for the sound slot; MDIN is valid in this cycle.
- FREQ  out  1  memory-cycle request to the bus arbiter.
- ADDR  out  ADDR_W  word address of the fetch; valid while FREQ=1.
- SLOAD_N  out  1  active-low FIFO load strobe to the shifter.
- SINT  out  1  one-cycle frame-end pulse.
- ACTIVE  out  1  level, high while playing.

## Operation
Register map (A[5:1]):
- 0x00 control: bit0 PLAY, bit1 LOOP.
- 0x01/0x02/0x03 start hi/mid/lo.
- 0x04/0x05/0x06 counter hi/mid/lo, read-only.
- 0x07/0x08/0x09 end hi/mid/lo.
- lo byte bit0 is forced 0 on both write and read.
- Other indices read 0 and ignore writes.

Register access:
- Write strobe = CS & ~RW & ~CS_d (first cycle of the access). Exactly one write per access.
- Reads are combinational: DOUT = selected register when CS & RW, otherwise 0.

Shadow registers:
- start_s/end_s are loaded from start/end at ARM and at each loop restart.
- CPU writes to start/end never disturb the frame currently playing.

FSM:
- IDLE: ACTIVE=0. Go to ARM when PLAY=1.
- ARM (1 cycle): cnt ← start, load shadows, ACTIVE=1.
  - start == end: go to FEND.
  - otherwise: go to WAIT.
- WAIT: go to REQ when SREQ=1.
- REQ: FREQ=1, ADDR=cnt. On GNT go to LOAD.
- LOAD (1 cycle): SLOAD_N=0; cnt ← cnt+1 (wraps to 0 at 2^ADDR_W).
  - new cnt == end_s: go to FEND.
  - otherwise: go to GAP.
- GAP (1 cycle): SLOAD_N=1 (guaranteed high cycle), then go to WAIT.
- FEND (1 cycle): SINT=1.
  - LOOP=1 and PLAY=1: go to ARM.
  - otherwise: clear PLAY, go to IDLE.

PLAY written 0:
- In any state except LOAD/GAP/FEND: go to IDLE the next cycle and drop FREQ.
- A GNT arriving in the same cycle as the stop write is ignored: no load.
- In LOAD/GAP: the load in progress completes, then go to IDLE. No SINT.

Other boundary rules:
- A PLAY=1 write while already active has no effect.
- LOOP may change at any time; it is sampled only in FEND.
- end_s below start_s: the counter wraps through 0 and stops when it reaches end_s.

## Timing
Reset values:
- FREQ=0, SLOAD_N=1, SINT=0, ACTIVE=0, ADDR=0, DOUT=0.
- All registers 0; state IDLE.

Latencies:
- PLAY write cycle T → ARM at T+1 → WAIT at T+2. With SREQ=1, FREQ rises at T+3.
- GNT at cycle G → SLOAD_N low in G+1 only, high in G+2.
- Next FREQ no earlier than G+4. Minimum 4 cycles per word.
- Frame end: SINT is high in the cycle after the last LOAD.
- Loop restart: FREQ re-asserts 3 cycles after SINT when SREQ=1.

SREQ handling:
- SREQ is sampled only in WAIT. SREQ dropping during REQ does not cancel the request; the FIFO guarantees one free slot per request.

## Structure
Shared package snd_dma_pkg:
- Register index constants (REG_CTRL, REG_START_H…REG_END_L).
- State enum {IDLE, ARM, WAIT, REQ, LOAD, GAP, FEND}.
- Control bit positions.

Sub-module snd_dma_regs:
- CPU register file, write-strobe edge detect, DOUT mux.
- Exports start, end, PLAY, LOOP.
- Accepts a clear-PLAY pulse and the live counter for readback.

The top level holds the FSM, counter and shadow registers.

## Test plan
- Start 0x010000, end 0x010008, SREQ=1, PLAY=1 → 4 GNTs at words 0x8000–0x8003, 4 SLOAD_N pulses, one SINT, ACTIVE falls, control reads 0x00.
- Same frame with LOOP=1; start rewritten to 0x020000 mid-frame → frame 1 completes from the old start; frame 2 begins at ADDR=0x10000 words. SINT once per frame.
- start == end = 0x030000, PLAY=1 → no FREQ, SINT 2 cycles after the write, ACTIVE returns to 0.
- Hold SREQ=0 for 50 cycles in WAIT → FREQ stays 0. SREQ=1 → FREQ the next cycle. Counter readback (0x04–0x06) tracks each LOAD.
- PLAY=0 written in the same cycle as GNT → no SLOAD_N pulse, FREQ=0 the next cycle, no SINT. Separately, resb pulsed low during REQ → all outputs at reset values immediately.
- Start 0xFFFFFE, end 0x000002 → ADDR sequence 0x7FFFFF then 0x000000. Stops after 2 words with SINT.
